// File: rtl/garduino_sys_v1_sys_cpu_v1_oci_dct_packer.sv
// Packs 2-bit DCT trace atoms into 30-bit words of up to 15 atoms and hands them to the
// trace FIFO over valid/ready, exposing the live accumulation state to the OCI monitor.
module garduino_sys_v1_sys_cpu_v1_oci_dct_packer #(
    parameter int ATOM_W = 2,
    parameter int ATOMS  = 15,
    parameter int CNT_W  = 4,
    parameter int DROP_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    trace_en,
    input  logic                    atom_valid,
    input  logic [ATOM_W-1:0]       atom_data,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ATOM_W*ATOMS-1:0] out_data,
    output logic [CNT_W-1:0]        out_count,
    output logic [ATOM_W*ATOMS-1:0] dct_buffer,
    output logic [CNT_W-1:0]        dct_count,
    output logic                    overflow,
    output logic [DROP_W-1:0]       drop_count
);

    localparam int               BUF_W    = ATOM_W * ATOMS;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ATOMS);

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [BUF_W-1:0]  r_buf;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_out_valid;
    logic [BUF_W-1:0]  r_out_data;
    logic [CNT_W-1:0]  r_out_count;
    logic              r_flush_pend;
    logic              r_overflow;
    logic [DROP_W-1:0] r_drop_cnt;

    logic              w_cap;
    logic              w_free;
    logic              w_fl;
    logic              w_full;
    logic              w_empty;
    logic              w_append;
    logic              w_xfer;
    logic              w_drop;
    logic              w_idle_flush;
    logic [BUF_W-1:0]  w_buf_app;
    logic [CNT_W-1:0]  w_cnt_app;

    assign w_cap        = trace_en && atom_valid;
    assign w_free       = !r_out_valid || out_ready;
    assign w_fl         = flush || r_flush_pend;
    assign w_full       = (r_cnt == FULL_CNT);
    assign w_empty      = (r_cnt == '0);
    assign w_append     = w_cap && !w_full;
    assign w_xfer       = w_free && (w_full || (w_fl && (!w_empty || w_cap)));
    assign w_drop       = w_cap && w_full && !w_xfer;
    // An empty flush with nothing arriving has nothing to emit, so it is simply retired.
    assign w_idle_flush = w_fl && w_empty && !w_cap;
    assign w_cnt_app    = r_cnt + CNT_W'(w_append);

    always_comb begin
        w_buf_app = r_buf;
        if (w_append) begin
            w_buf_app[int'(r_cnt)*ATOM_W +: ATOM_W] = atom_data;
        end
    end

    // Stage boundary: accumulation buffer, output slot and drop bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf        <= '0;
            r_cnt        <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_count  <= '0;
            r_flush_pend <= 1'b0;
            r_overflow   <= 1'b0;
            r_drop_cnt   <= '0;
        end else begin
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_buf_app;
                r_out_count <= w_cnt_app;
                // A capture that meets a full buffer opens the next word instead of being lost.
                if (w_full && w_cap) begin
                    r_buf <= BUF_W'(atom_data);
                    r_cnt <= CNT_W'(1);
                end else begin
                    r_buf <= '0;
                    r_cnt <= '0;
                end
            end else begin
                if (r_out_valid && out_ready) begin
                    r_out_valid <= 1'b0;
                end
                if (w_append) begin
                    r_buf <= w_buf_app;
                    r_cnt <= w_cnt_app;
                end
            end

            if (w_xfer || w_idle_flush) begin
                r_flush_pend <= 1'b0;
            end else if (w_fl && !w_free) begin
                r_flush_pend <= 1'b1;
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
                r_drop_cnt <= sat_inc(r_drop_cnt);
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_count  = r_out_count;
    assign dct_buffer = r_buf;
    assign dct_count  = r_cnt;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_cnt;

endmodule

// File: tb/tb_garduino_sys_v1_sys_cpu_v1_oci_dct_packer.sv
// Randomized and directed bench for the DCT packer, checked every cycle against a
// queue-based model of the atom buffer and the held output word.
module tb_garduino_sys_v1_sys_cpu_v1_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        trace_en = 1'b0;
    logic        atom_valid = 1'b0;
    logic [1:0]  atom_data = 2'd0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [29:0] out_data;
    logic [3:0]  out_count;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        overflow;
    logic [7:0]  drop_count;

    garduino_sys_v1_sys_cpu_v1_oci_dct_packer dut (
        .clk        (clk),
        .reset      (reset),
        .trace_en   (trace_en),
        .atom_valid (atom_valid),
        .atom_data  (atom_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_count  (out_count),
        .dct_buffer (dct_buffer),
        .dct_count  (dct_count),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: atoms waiting in the buffer, atoms of the word in the output slot.
    int mq[$];
    int mw[$];
    bit mv    = 1'b0;
    bit mpend = 1'b0;
    bit mov   = 1'b0;
    int mdrops = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack_q(input int q[$]);
        logic [31:0] e = 32'd0;
        foreach (q[k]) e |= 32'(q[k]) << (2 * k);
        return e;
    endfunction

    task automatic step(input bit rst, input bit en, input bit av, input int ad,
                        input bit fl_in, input bit rdy);
        bit cap, free, fl, xfer;
        int n;
        int nq[$];
        int nw[$];
        bit nv, npend, nov;
        int nd;
        reset      = rst;
        trace_en   = en;
        atom_valid = av;
        atom_data  = 2'(ad);
        flush      = fl_in;
        out_ready  = rdy;

        n    = mq.size();
        cap  = en && av;
        free = !mv || rdy;
        fl   = fl_in || mpend;
        xfer = free && (n == 15 || (fl && (n != 0 || cap)));
        nq = mq; nw = mw; nv = mv; npend = mpend; nov = mov; nd = mdrops;
        if (xfer) begin
            nw = mq;
            nq.delete();
            if (cap) begin
                if (n < 15) nw.push_back(ad & 3);
                else        nq.push_back(ad & 3);
            end
            nv = 1'b1;
        end else begin
            if (mv && rdy) nv = 1'b0;
            if (cap) begin
                if (n < 15) nq.push_back(ad & 3);
                else begin
                    nov = 1'b1;
                    if (nd < 255) nd++;
                end
            end
        end
        if (xfer || (fl && n == 0 && !cap)) npend = 1'b0;
        else if (fl && !free)               npend = 1'b1;
        if (rst) begin
            nq.delete(); nw.delete();
            nv = 1'b0; npend = 1'b0; nov = 1'b0; nd = 0;
        end

        @(posedge clk);
        #1;
        mq = nq; mw = nw; mv = nv; mpend = npend; mov = nov; mdrops = nd;

        chk("dct_count",  32'(dct_count),  32'(mq.size()));
        chk("dct_buffer", 32'(dct_buffer), pack_q(mq));
        chk("out_valid",  32'(out_valid),  32'(mv));
        chk("out_count",  32'(out_count),  32'(mw.size()));
        chk("out_data",   32'(out_data),   pack_q(mw));
        chk("overflow",   32'(overflow),   32'(mov));
        chk("drop_count", 32'(drop_count), 32'(mdrops));
    endtask

    task automatic atom(input int a, input bit rdy);
        step(1'b0, 1'b1, 1'b1, a, 1'b0, rdy);
    endtask

    task automatic idle(input int cycles, input bit rdy);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b1, 1'b0, 0, 1'b0, rdy);
    endtask

    initial begin
        // Reset state.
        step(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1);

        // Full word of the repeating pattern 0,1,2,3,...
        for (int i = 0; i < 15; i++) atom(i % 4, 1'b1);
        idle(1, 1'b1);
        chk("t1_count", 32'(out_count), 32'd15);
        chk("t1_data",  32'(out_data),  32'h24E4E4E4);
        idle(2, 1'b1);

        // Partial word via flush.
        atom(3, 1'b1); atom(1, 1'b1); atom(2, 1'b1);
        step(1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b1);
        chk("t2_count", 32'(out_count), 32'd3);
        chk("t2_data",  32'(out_data),  32'h27);
        chk("t2_buf",   32'(dct_buffer), 32'd0);
        idle(2, 1'b1);

        // Blocked output: held word, full buffer, then two drops.
        for (int i = 0; i < 15; i++) atom($urandom_range(0, 3), 1'b0);
        for (int i = 0; i < 17; i++) atom($urandom_range(0, 3), 1'b0);
        chk("t3_ovf",  32'(overflow),   32'd1);
        chk("t3_drop", 32'(drop_count), 32'd2);
        idle(4, 1'b1);

        // Full buffer with a capture in the transfer cycle.
        for (int i = 0; i < 16; i++) atom(i == 15 ? 2 : (i + 1) % 4, 1'b1);
        chk("t4_cnt", 32'(dct_count), 32'd1);
        chk("t4_buf", 32'(dct_buffer), 32'd2);
        step(1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b1);
        idle(2, 1'b1);

        // Flush while the output slot is held.
        for (int i = 0; i < 15; i++) atom($urandom_range(0, 3), 1'b0);
        for (int i = 0; i < 5; i++)  atom($urandom_range(0, 3), 1'b0);
        step(1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0);
        idle(3, 1'b0);
        idle(2, 1'b1);
        chk("t5_count", 32'(out_count), 32'd5);
        idle(2, 1'b1);

        // Reset with atoms buffered and a word held.
        for (int i = 0; i < 15; i++) atom($urandom_range(0, 3), 1'b0);
        for (int i = 0; i < 7; i++)  atom($urandom_range(0, 3), 1'b0);
        step(1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b1);
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_cnt",   32'(dct_count), 32'd0);
        idle(2, 1'b1);

        // Drop counter saturation.
        for (int i = 0; i < 15; i++) atom($urandom_range(0, 3), 1'b0);
        for (int i = 0; i < 15; i++) atom($urandom_range(0, 3), 1'b0);
        for (int i = 0; i < 262; i++) atom($urandom_range(0, 3), 1'b0);
        chk("sat_drop", 32'(drop_count), 32'd255);
        step(1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0);
        idle(4, 1'b1);
        step(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1);

        // Randomized traffic with shifting backpressure.
        begin
            int rdy_pct = 100;
            for (int c = 0; c < 4000; c++) begin
                if (c % 200 == 0) rdy_pct = $urandom_range(0, 100);
                step(($urandom_range(0, 399) == 0),
                     ($urandom_range(0, 7) != 0),
                     ($urandom_range(0, 3) != 0),
                     $urandom_range(0, 3),
                     ($urandom_range(0, 11) == 0),
                     ($urandom_range(1, 100) <= rdy_pct));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
